// File: rtl/sram_port0_ctrl_if.sv
// Request/response stream between fabric logic and the SRAM port controller.
// The controller is the slave of the request stream and the source of responses.
interface sram_port0_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port0_ctrl.sv
// Single-port OpenRAM RW initiator: zero-fills the array, then turns a valid/ready
// request stream into macro cycles and returns read data through a 4-entry FIFO.
//
// state    | meaning
// ST_INIT  | fill engine writes INIT_VALUE to every word, no traffic accepted
// ST_RUN   | requests accepted while credits remain and clr is low
// ST_DRAIN | waits for in-flight reads to land in the FIFO before refilling
module sram_port0_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    input  logic                   clr,
    sram_port0_ctrl_if.slave       bus,
    output logic                   init_done,
    output logic                   csb0,
    output logic                   web0,
    output logic [ADDR_WIDTH-1:0]  addr0,
    output logic [DATA_WIDTH-1:0]  din0,
    input  logic [DATA_WIDTH-1:0]  dout0
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    localparam int             FCW      = ADDR_WIDTH + 1;
    localparam logic [FCW-1:0] FILL_END = FCW'(RAM_DEPTH);

    state_t                state_q, state_d;
    logic [FCW-1:0]        fill_q, fill_d;
    logic                  init_done_q, init_done_d;
    logic                  armed_q, armed_d;
    logic                  issue_vld_q, issue_vld_d;
    logic                  issue_we_q, issue_we_d;
    logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
    logic [DATA_WIDTH-1:0] issue_data_q, issue_data_d;
    logic                  rd_cap_q;
    logic [2:0]            credits_q;
    logic                  ready_c;
    logic                  accept_rd;
    logic                  pop;

    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_cnt;

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        init_done_d  = init_done_q;
        armed_d      = armed_q | ~clr;
        issue_vld_d  = 1'b0;
        issue_we_d   = 1'b0;
        issue_addr_d = issue_addr_q;
        issue_data_d = issue_data_q;
        ready_c      = 1'b0;
        accept_rd    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (fill_q == FILL_END) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    issue_vld_d  = 1'b1;
                    issue_we_d   = 1'b1;
                    issue_addr_d = fill_q[ADDR_WIDTH-1:0];
                    issue_data_d = INIT_VALUE;
                    fill_d       = fill_q + FCW'(1);
                end
            end
            ST_RUN: begin
                // A held clr refills only once; it must drop before it can trigger again.
                if (clr && armed_q) begin
                    state_d     = ST_DRAIN;
                    init_done_d = 1'b0;
                    armed_d     = 1'b0;
                end
                ready_c = !clr && (credits_q != 3'd4);
                if (ready_c && bus.req_valid) begin
                    issue_vld_d  = 1'b1;
                    issue_we_d   = bus.req_we;
                    issue_addr_d = bus.req_addr;
                    issue_data_d = bus.req_wdata;
                    accept_rd    = !bus.req_we;
                end
            end
            ST_DRAIN: begin
                if (!(issue_vld_q && !issue_we_q) && !rd_cap_q) begin
                    state_d = ST_INIT;
                    fill_d  = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign pop           = (fifo_cnt != 3'd0) && bus.rsp_ready;
    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (fifo_cnt != 3'd0);
    assign bus.rsp_rdata = fifo_mem[rd_ptr];
    assign init_done     = init_done_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q      <= ST_INIT;
            fill_q       <= '0;
            init_done_q  <= 1'b0;
            armed_q      <= 1'b1;
            issue_vld_q  <= 1'b0;
            issue_we_q   <= 1'b0;
            issue_addr_q <= '0;
            issue_data_q <= '0;
            rd_cap_q     <= 1'b0;
            credits_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            init_done_q  <= init_done_d;
            armed_q      <= armed_d;
            issue_vld_q  <= issue_vld_d;
            issue_we_q   <= issue_we_d;
            issue_addr_q <= issue_addr_d;
            issue_data_q <= issue_data_d;
            rd_cap_q     <= issue_vld_q && !issue_we_q;
            unique case ({accept_rd, pop})
                2'b10:   credits_q <= credits_q + 3'd1;
                2'b01:   credits_q <= credits_q - 3'd1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    // The macro captured the read one edge ago; its dout0 is valid now.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (rd_cap_q) begin
                fifo_mem[wr_ptr] <= dout0;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            unique case ({rd_cap_q, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Falling-edge launch keeps the macro pins stable around its capturing rising edge.
    always_ff @(negedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            addr0 <= '0;
            din0  <= '0;
        end else if (issue_vld_q) begin
            csb0  <= 1'b0;
            web0  <= !issue_we_q;
            addr0 <= issue_addr_q;
            din0  <= issue_data_q;
        end else begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural macro, memory/response scoreboard,
// directed scenarios and a randomized traffic phase.
module tb_sram_port0_ctrl;
    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        clr;
    logic        init_done;
    logic        csb0, web0;
    logic [7:0]  addr0;
    logic [15:0] din0;
    logic [15:0] dout0 = 16'h0;
    logic        scramble = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int cyc   = 0;

    sram_port0_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    sram_port0_ctrl dut (
        .clk0      (clk0),
        .rst0_n    (rst0_n),
        .clr       (clr),
        .bus       (bus),
        .init_done (init_done),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    always #5 clk0 = ~clk0;

    // behavioural single-port macro
    logic [15:0] sram [256];
    always @(posedge clk0) begin
        if (scramble) begin
            foreach (sram[i]) sram[i] <= 16'($urandom);
        end else if (!csb0) begin
            if (!web0) sram[addr0] <= din0;
            else       dout0       <= sram[addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference model: word memory plus in-order expected responses with ready cycle
    typedef struct { logic [15:0] data; int rdy; } exp_t;
    exp_t        exp_q [$];
    exp_t        e;
    logic [15:0] model_mem [256];
    logic        exp_rv;

    always @(posedge clk0) begin
        if (!rst0_n) begin
            exp_q.delete();
            foreach (model_mem[i]) model_mem[i] = 16'h0;
        end else begin
            cyc++;
            exp_rv = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            chk("req_ready", bus.req_ready, init_done ? (!clr && exp_q.size() < 4) : 1'b0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_pop++;
                if (exp_q.size() == 0) chk("rsp_extra", bus.rsp_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.data);
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) model_mem[bus.req_addr] = bus.req_wdata;
                else exp_q.push_back('{model_mem[bus.req_addr], cyc + 3});
            end
        end
    end

    task automatic step();
        @(negedge clk0);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int t = 0; t < 50; t++) begin
            if (bus.req_ready) begin
                step();
                bus.req_valid = 1'b0;
                return;
            end
            step();
        end
        bus.req_valid = 1'b0;
        chk("req_timeout", bus.req_ready, 1'b1);
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic wait_init(input int bound);
        for (int t = 0; t < bound; t++) begin
            if (init_done) break;
            step();
        end
        chk("init_timeout", init_done, 1'b1);
    endtask

    int acc, cnt, runs, pops0;
    logic prev_v;

    initial begin
        rst0_n = 1'b0;
        clr = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = 8'h0;
        bus.req_wdata = 16'h0;
        bus.rsp_ready = 1'b0;
        step();
        scramble = 1'b1;
        step();
        scramble = 1'b0;
        step();

        chk("rst_csb0", csb0, 1'b1);
        chk("rst_web0", web0, 1'b1);
        chk("rst_addr0", addr0, 8'h0);
        chk("rst_din0", din0, 16'h0);
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 16'h0);
        chk("rst_init_done", init_done, 1'b0);

        // fill after reset with a read request already waiting
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 8'h3C;
        rst0_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            chk("fill_csb0", csb0, 1'b0);
            chk("fill_web0", web0, 1'b0);
            chk("fill_addr0", addr0, k);
            chk("fill_din0", din0, 16'h0);
            chk("fill_init_done", init_done, 1'b0);
        end
        step();
        chk("e256_init_done", init_done, 1'b1);
        chk("e256_req_ready", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        drain();

        // write then read-after-write of the same word
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 8'h10;
        bus.req_wdata = 16'hA5A5;
        chk("wtr_ready_w", bus.req_ready, 1'b1);
        step();
        chk("wtr_csb_w", csb0, 1'b0);
        chk("wtr_web_w", web0, 1'b0);
        chk("wtr_addr_w", addr0, 8'h10);
        chk("wtr_din_w", din0, 16'hA5A5);
        bus.req_we = 1'b0;
        chk("wtr_ready_r", bus.req_ready, 1'b1);
        step();
        chk("wtr_csb_r", csb0, 1'b0);
        chk("wtr_web_r", web0, 1'b1);
        bus.req_valid = 1'b0;
        step();
        chk("wtr_csb_idle", csb0, 1'b1);
        chk("wtr_rsp_early", bus.rsp_valid, 1'b0);
        step();
        chk("wtr_rsp_valid", bus.rsp_valid, 1'b1);
        chk("wtr_rsp_rdata", bus.rsp_rdata, 16'hA5A5);
        drain();

        // streaming reads of known data
        for (int i = 0; i < 8; i++) do_req(1'b1, 8'(i), 16'($urandom));
        bus.rsp_ready = 1'b1;
        cnt = 0;
        runs = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin
                bus.req_valid = 1'b1;
                bus.req_we = 1'b0;
                bus.req_addr = 8'(i);
                chk("stream_ready", bus.req_ready, 1'b1);
            end else bus.req_valid = 1'b0;
            if (bus.rsp_valid) cnt++;
            if (bus.rsp_valid && !prev_v) runs++;
            prev_v = bus.rsp_valid;
            step();
        end
        chk("stream_rsp_count", cnt, 8);
        chk("stream_rsp_runs", runs, 1);

        // backpressure: credits stop acceptance at four
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we = 1'b0;
            bus.req_addr = 8'(acc);
            if (bus.req_ready) acc++;
            step();
        end
        bus.req_valid = 1'b0;
        chk("bp_accepts", acc, 4);
        chk("bp_ready_low", bus.req_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        chk("bp_ready_before_pop", bus.req_ready, 1'b0);
        step();
        chk("bp_ready_after_pop", bus.req_ready, 1'b1);
        drain();

        // randomized traffic over a small address window
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = ($urandom_range(0, 1) == 1);
            bus.req_we = ($urandom_range(0, 2) == 0);
            bus.req_addr = 8'($urandom_range(0, 15));
            bus.req_wdata = 16'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = 1'b0;
        drain();

        // clr with two reads in flight
        pops0 = n_pop;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we = 1'b0;
            bus.req_addr = 8'(i);
            chk("clr_rd_ready", bus.req_ready, 1'b1);
            step();
        end
        bus.req_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        foreach (model_mem[i]) model_mem[i] = 16'h0;
        cnt = 0;
        for (int t = 0; t < 600; t++) begin
            if (init_done) break;
            if (!csb0 && !web0) cnt++;
            step();
        end
        chk("clr_init_done", init_done, 1'b1);
        chk("clr_fill_writes", cnt, 256);
        chk("clr_rsp_count", n_pop - pops0, 2);
        do_req(1'b0, 8'h10, 16'h0);
        drain();

        // reset between accept and capture of a write
        scramble = 1'b1;
        step();
        scramble = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 8'h33;
        bus.req_wdata = 16'h1234;
        @(posedge clk0);
        #1;
        bus.req_valid = 1'b0;
        #6;
        chk("abort_csb_pre", csb0, 1'b0);
        rst0_n = 1'b0;
        #1;
        chk("abort_csb0", csb0, 1'b1);
        chk("abort_web0", web0, 1'b1);
        chk("abort_addr0", addr0, 8'h0);
        chk("abort_din0", din0, 16'h0);
        chk("abort_req_ready", bus.req_ready, 1'b0);
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_rsp_rdata", bus.rsp_rdata, 16'h0);
        chk("abort_init_done", init_done, 1'b0);
        step();
        step();
        rst0_n = 1'b1;
        wait_init(300);
        do_req(1'b0, 8'h33, 16'h0);
        do_req(1'b0, 8'h3C, 16'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
